// File: rtl/prv32_div_unit.sv
// rtl/prv32_div_unit.sv - RV32M iterative restoring divider; optional last-result cache under PRV32_DIV_CACHE_EN
module prv32_div_unit (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [4:0]  alufn_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [4:0] FN_DIV  = 5'b01100;
    localparam logic [4:0] FN_DIVU = 5'b10000;
    localparam logic [4:0] FN_REM  = 5'b10001;
    localparam logic [4:0] FN_REMU = 5'b10010;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        sel_rem_q, sel_rem_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;

    logic        div_op, op_signed, op_rem;
    logic [31:0] abs_a, abs_b;
    logic [32:0] shift_rem, trial;
    logic [31:0] q_fix, r_fix;

`ifdef PRV32_DIV_CACHE_EN
    logic        cv_q, cv_d;
    logic [31:0] ca_q, ca_d, cb_q, cb_d;
    logic        cs_q, cs_d;
    logic [31:0] cq_q, cq_d, cr_q, cr_d;
    logic [31:0] opa_q, opa_d, opb_q, opb_d;
    logic        sgn_q, sgn_d;
    logic        hit;

    // A start hits when operands and signedness match the last completed divide
    always_comb begin
        hit = cv_q && (ca_q == a_i) && (cb_q == b_i) && (cs_q == op_signed);
    end
`endif

    // Decode the ALU code and form operand magnitudes (0x80000000 stays 2^31)
    always_comb begin
        div_op    = (alufn_i == FN_DIV) || (alufn_i == FN_DIVU) ||
                    (alufn_i == FN_REM) || (alufn_i == FN_REMU);
        op_signed = (alufn_i == FN_DIV) || (alufn_i == FN_REM);
        op_rem    = (alufn_i == FN_REM) || (alufn_i == FN_REMU);
        abs_a     = (op_signed && a_i[31]) ? (32'd0 - a_i) : a_i;
        abs_b     = (op_signed && b_i[31]) ? (32'd0 - b_i) : b_i;
    end

    // One restoring step: shift {rem,quo} left and trial-subtract the divisor
    always_comb begin
        shift_rem = {rem_q, quo_q[31]};
        trial     = shift_rem - {1'b0, dvs_q};
    end

    // Hold the pipeline while accepting and iterating; DONE lets EX/MEM capture
    assign stall_o = (start_i && div_op && (state_q == ST_IDLE)) || (state_q == ST_CALC);

    // Next-state, datapath and output register logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        sel_rem_d = sel_rem_q;
        result_d  = result_q;
`ifdef PRV32_DIV_CACHE_EN
        cv_d  = cv_q;
        ca_d  = ca_q;
        cb_d  = cb_q;
        cs_d  = cs_q;
        cq_d  = cq_q;
        cr_d  = cr_q;
        opa_d = opa_q;
        opb_d = opb_q;
        sgn_d = sgn_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i && div_op) begin
                    sel_rem_d = op_rem;
                    qneg_d    = 1'b0;
                    rneg_d    = 1'b0;
                    if (b_i == 32'd0) begin
                        quo_d   = 32'hFFFF_FFFF;
                        rem_d   = a_i;
                        state_d = ST_DONE;
                    end else if (op_signed && (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF)) begin
                        quo_d   = 32'h8000_0000;
                        rem_d   = 32'd0;
                        state_d = ST_DONE;
`ifdef PRV32_DIV_CACHE_EN
                    end else if (hit) begin
                        quo_d   = cq_q;
                        rem_d   = cr_q;
                        state_d = ST_DONE;
`endif
                    end else begin
                        quo_d   = abs_a;
                        rem_d   = 32'd0;
                        dvs_d   = abs_b;
                        qneg_d  = op_signed && (a_i[31] ^ b_i[31]);
                        rneg_d  = op_signed && a_i[31];
                        cnt_d   = 5'd31;
                        state_d = ST_CALC;
`ifdef PRV32_DIV_CACHE_EN
                        opa_d   = a_i;
                        opb_d   = b_i;
                        sgn_d   = op_signed;
`endif
                    end
                end
            end
            ST_CALC: begin
                if (!trial[32]) begin
                    rem_d = trial[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = shift_rem[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                if (cnt_q == 5'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush_i) begin
            state_d = ST_IDLE;
`ifdef PRV32_DIV_CACHE_EN
            cv_d = 1'b0;
`endif
        end

        q_fix  = qneg_d ? (32'd0 - quo_d) : quo_d;
        r_fix  = rneg_d ? (32'd0 - rem_d) : rem_d;
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        if (state_d == ST_DONE) begin
            result_d = sel_rem_d ? r_fix : q_fix;
        end
`ifdef PRV32_DIV_CACHE_EN
        if ((state_q == ST_CALC) && (state_d == ST_DONE)) begin
            cv_d = 1'b1;
            ca_d = opa_q;
            cb_d = opb_q;
            cs_d = sgn_q;
            cq_d = q_fix;
            cr_d = r_fix;
        end
`endif
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 5'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            dvs_q     <= 32'd0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            sel_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= 32'd0;
`ifdef PRV32_DIV_CACHE_EN
            cv_q  <= 1'b0;
            ca_q  <= 32'd0;
            cb_q  <= 32'd0;
            cs_q  <= 1'b0;
            cq_q  <= 32'd0;
            cr_q  <= 32'd0;
            opa_q <= 32'd0;
            opb_q <= 32'd0;
            sgn_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            sel_rem_q <= sel_rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
`ifdef PRV32_DIV_CACHE_EN
            cv_q  <= cv_d;
            ca_q  <= ca_d;
            cb_q  <= cb_d;
            cs_q  <= cs_d;
            cq_q  <= cq_d;
            cr_q  <= cr_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
            sgn_q <= sgn_d;
`endif
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_prv32_div_unit.sv
// tb/tb_prv32_div_unit.sv - Randomized self-checking bench for prv32_div_unit
module tb_prv32_div_unit;

    localparam logic [4:0] FN_DIV  = 5'b01100;
    localparam logic [4:0] FN_DIVU = 5'b10000;
    localparam logic [4:0] FN_REM  = 5'b10001;
    localparam logic [4:0] FN_REMU = 5'b10010;
`ifdef PRV32_DIV_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        clk, rst_n, start, flush;
    logic [4:0]  alufn;
    logic [31:0] a, b;
    logic        stall, busy, done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    logic        c_valid;
    logic [31:0] c_a, c_b;
    logic        c_sgn;

    prv32_div_unit dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .start_i  (start),
        .alufn_i  (alufn),
        .a_i      (a),
        .b_i      (b),
        .flush_i  (flush),
        .stall_o  (stall),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic is_signed(input logic [4:0] fn);
        return (fn == FN_DIV) || (fn == FN_REM);
    endfunction

    function automatic logic [31:0] model_res(input logic [4:0] fn, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        if (fn == FN_DIVU) return (y == 0) ? 32'hFFFF_FFFF : x / y;
        if (fn == FN_REMU) return (y == 0) ? x : x % y;
        if (y == 0) return (fn == FN_DIV) ? 32'hFFFF_FFFF : x;
        sx = $signed(x);
        sy = $signed(y);
        q  = sx / sy;
        r  = sx % sy;
        return (fn == FN_DIV) ? q[31:0] : r[31:0];
    endfunction

    function automatic int model_lat(input logic [4:0] fn, input logic [31:0] x, input logic [31:0] y);
        if (y == 0) return 1;
        if (is_signed(fn) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        if (CACHE && c_valid && c_a == x && c_b == y && c_sgn == is_signed(fn)) return 1;
        return 33;
    endfunction

    task automatic run_op(input logic [4:0] fn, input logic [31:0] opa, input logic [31:0] opb,
                          input bit poke, input string tag);
        logic [31:0] exp_res;
        int exp_lat, lat;
        exp_res = model_res(fn, opa, opb);
        exp_lat = model_lat(fn, opa, opb);
        start = 1'b1; alufn = fn; a = opa; b = opb;
        #1;
        total++;
        if (stall !== 1'b1) begin bad++; $display("FAIL %s accept_stall got=%b want=1", tag, stall); end
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin lat = k; break; end
            if (poke && k == 3) begin start = 1'b1; alufn = FN_DIV; a = 32'd7; b = 32'd2; end
            if (poke && k == 4) begin start = 1'b0; alufn = fn; end
        end
        total++;
        if (lat != exp_lat) begin bad++; $display("FAIL %s latency got=%0d want=%0d (a=%h b=%h fn=%b)", tag, lat, exp_lat, opa, opb, fn); end
        if (lat != 0) begin
            total++;
            if (result !== exp_res) begin bad++; $display("FAIL %s result got=%h want=%h (a=%h b=%h fn=%b)", tag, result, exp_res, opa, opb, fn); end
            total++;
            if (stall !== 1'b0) begin bad++; $display("FAIL %s done_stall got=%b want=0", tag, stall); end
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL %s after_done done=%b busy=%b want 0 0", tag, done, busy); end
        if (exp_lat == 33) begin c_valid = 1'b1; c_a = opa; c_b = opb; c_sgn = is_signed(fn); end
    endtask

    task automatic test_reset;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || stall !== 1'b0) begin
            bad++; $display("FAIL reset_hold busy=%b done=%b result=%h stall=%b want all 0", busy, done, result, stall);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            bad++; $display("FAIL reset_release busy=%b done=%b result=%h want all 0", busy, done, result);
        end
    endtask

    task automatic test_directed;
        run_op(FN_DIVU, 32'd100, 32'd7, 1'b0, "divu_100_7");
        run_op(FN_REMU, 32'd100, 32'd7, 1'b0, "remu_100_7");
        run_op(FN_DIV,  32'hFFFF_FF9C, 32'd7, 1'b0, "div_m100_7");
        run_op(FN_REM,  32'hFFFF_FF9C, 32'd7, 1'b0, "rem_m100_7");
        run_op(FN_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        run_op(FN_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "rem_ovf");
        run_op(FN_DIVU, 32'h1234_5678, 32'd0, 1'b0, "divu_zero");
        run_op(FN_REMU, 32'h1234_5678, 32'd0, 1'b0, "remu_zero");
        run_op(FN_DIV,  32'hFFFF_FFFB, 32'd0, 1'b0, "div_zero");
        run_op(FN_REM,  32'hFFFF_FFFB, 32'd0, 1'b0, "rem_zero");
        run_op(FN_DIV,  32'h8000_0000, 32'd1, 1'b0, "div_min_1");
        run_op(FN_REM,  32'h7FFF_FFFF, 32'h8000_0000, 1'b0, "rem_max_min");
    endtask

    task automatic test_nondivide;
        logic [4:0] codes [3];
        logic [31:0] held;
        codes[0] = 5'b00000; codes[1] = 5'b01101; codes[2] = 5'b10011;
        held = result;
        for (int i = 0; i < 3; i++) begin
            start = 1'b1; alufn = codes[i]; a = 32'd50; b = 32'd5;
            #1;
            total++;
            if (stall !== 1'b0) begin bad++; $display("FAIL nondiv_stall code=%b got=%b want=0", codes[i], stall); end
            @(negedge clk);
            total++;
            if (busy !== 1'b0 || done !== 1'b0 || result !== held) begin
                bad++; $display("FAIL nondiv_idle code=%b busy=%b done=%b result=%h want 0 0 %h", codes[i], busy, done, result, held);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_start_while_busy;
        run_op(FN_DIVU, 32'd1000, 32'd10, 1'b1, "start_while_busy");
    endtask

    task automatic test_flush;
        bit saw_done;
        run_op(FN_DIVU, 32'd50, 32'd5, 1'b0, "pre_flush");
        start = 1'b1; alufn = FN_DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        saw_done = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b want=0", busy); end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        total++;
        if (saw_done) begin bad++; $display("FAIL flush_done_pulse got=1 want=0"); end
        total++;
        if (result !== 32'd10) begin bad++; $display("FAIL flush_result got=%h want=%h", result, 32'd10); end
        c_valid = 1'b0;
        run_op(FN_DIVU, 32'd9, 32'd3, 1'b0, "post_flush");
    endtask

    task automatic test_reset_mid;
        start = 1'b1; alufn = FN_DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 5; k++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || stall !== 1'b0) begin
            bad++; $display("FAIL reset_mid busy=%b done=%b result=%h stall=%b want all 0", busy, done, result, stall);
        end
        c_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (stall !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_mid_release stall=%b busy=%b want 0 0", stall, busy); end
    endtask

    task automatic test_random;
        logic [4:0] fns [4];
        logic [4:0] fn;
        logic [31:0] opa, opb;
        int sel;
        fns[0] = FN_DIV; fns[1] = FN_DIVU; fns[2] = FN_REM; fns[3] = FN_REMU;
        opa = $urandom; opb = $urandom;
        for (int i = 0; i < 24; i++) begin
            fn  = fns[$urandom_range(0, 3)];
            sel = $urandom_range(0, 9);
            if (sel != 3) opa = $urandom;
            case (sel)
                0: opb = 32'd0;
                1: opb = $urandom_range(1, 15);
                2: begin opa = 32'h8000_0000; opb = 32'hFFFF_FFFF; end
                3: ;
                default: opb = $urandom >> $urandom_range(0, 31);
            endcase
            run_op(fn, opa, opb, 1'b0, "random");
        end
    endtask

    task automatic test_back_to_back;
        run_op(FN_DIVU, 32'hDEAD_BEEF, 32'd1234, 1'b0, "b2b_0");
        run_op(FN_REM,  32'hDEAD_BEEF, 32'd1234, 1'b0, "b2b_1");
        run_op(FN_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 1'b0, "b2b_2");
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; alufn = 5'd0; a = 32'd0; b = 32'd0;
        c_valid = 1'b0; c_a = 32'd0; c_b = 32'd0; c_sgn = 1'b0;
        repeat (3) @(negedge clk);
        test_reset;
        test_directed;
        test_nondivide;
        test_start_while_busy;
        test_flush;
        test_reset_mid;
        test_random;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
